// File: rtl/argmax_classifier.sv
// Argmax over one NUM_CLASSES-beat score vector; emits the winning class and score as one held result beat.
// Optional ARGMAX_MARGIN_EN adds out_margin (top-1 minus top-2 score).
module argmax_classifier #(
    parameter int NUM_CLASSES   = 10,
    parameter int FEATURE_WIDTH = 16
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic signed [FEATURE_WIDTH-1:0]       in_feature,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic        [$clog2(NUM_CLASSES)-1:0] out_class,
    output logic signed [FEATURE_WIDTH-1:0]       out_score
`ifdef ARGMAX_MARGIN_EN
    ,
    output logic        [FEATURE_WIDTH-1:0]       out_margin
`endif
);

    localparam int CLS_W = $clog2(NUM_CLASSES);
    localparam int CNT_W = CLS_W + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_CLASSES - 1);

    typedef enum logic {S_RECV, S_RESULT} state_t;

    state_t                          state;
    logic        [CNT_W-1:0]         beat_cnt;
    logic                            take;
    logic                            last_beat;
    logic signed [FEATURE_WIDTH-1:0] nxt_score;
    logic        [CLS_W-1:0]         nxt_class;

`ifdef ARGMAX_MARGIN_EN
    localparam logic signed [FEATURE_WIDTH-1:0] MOST_NEG = {1'b1, {(FEATURE_WIDTH-1){1'b0}}};
    logic signed [FEATURE_WIDTH-1:0] second_score;
    logic signed [FEATURE_WIDTH-1:0] nxt_second;
    logic signed [FEATURE_WIDTH:0]   margin_full;
`endif

    // out_score/out_class double as the running-max registers; they only
    // change on accepted beats, so they hold naturally through S_RESULT.
    always_comb begin
        take      = in_valid & in_ready;
        last_beat = take && (beat_cnt == LAST_BEAT);
        nxt_score = out_score;
        nxt_class = out_class;
`ifdef ARGMAX_MARGIN_EN
        nxt_second = second_score;
`endif
        if (take) begin
            if (beat_cnt == '0) begin
                nxt_score = in_feature;
                nxt_class = '0;
`ifdef ARGMAX_MARGIN_EN
                nxt_second = MOST_NEG;
`endif
            end else if (in_feature > out_score) begin
                nxt_score = in_feature;
                nxt_class = beat_cnt[CLS_W-1:0];
`ifdef ARGMAX_MARGIN_EN
                nxt_second = out_score;
`endif
            end
`ifdef ARGMAX_MARGIN_EN
            else if (in_feature > second_score) begin
                // a tie with the max lands here too, giving a zero margin
                nxt_second = in_feature;
            end
`endif
        end
`ifdef ARGMAX_MARGIN_EN
        margin_full = {nxt_score[FEATURE_WIDTH-1], nxt_score}
                    - {nxt_second[FEATURE_WIDTH-1], nxt_second};
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= S_RECV;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            beat_cnt  <= '0;
            out_class <= '0;
            out_score <= '0;
`ifdef ARGMAX_MARGIN_EN
            second_score <= '0;
            out_margin   <= '0;
`endif
        end else begin
            out_score <= nxt_score;
            out_class <= nxt_class;
`ifdef ARGMAX_MARGIN_EN
            second_score <= nxt_second;
`endif
            case (state)
                S_RECV: begin
                    if (last_beat) begin
                        state     <= S_RESULT;
                        in_ready  <= 1'b0;
                        out_valid <= 1'b1;
                        beat_cnt  <= '0;
`ifdef ARGMAX_MARGIN_EN
                        out_margin <= FEATURE_WIDTH'(margin_full);
`endif
                    end else if (take) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                S_RESULT: begin
                    if (out_ready) begin
                        state     <= S_RECV;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_RECV;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_classifier.sv
// Directed bench for argmax_classifier (NUM_CLASSES=10, FEATURE_WIDTH=16); margin checks when ARGMAX_MARGIN_EN is defined.
module tb_argmax_classifier;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_feature;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_class;
    logic [15:0] out_score;
`ifdef ARGMAX_MARGIN_EN
    logic [15:0] out_margin;
`endif

    int          npass = 0;
    int          ntotal = 0;
    logic [15:0] img[10];
    logic [15:0] img2[20];
    logic [3:0]  res_class[2];
    logic [15:0] res_score[2];
    int          nres;
    int          idx;
    logic        acc;

    argmax_classifier #(.NUM_CLASSES(10), .FEATURE_WIDTH(16)) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_feature (in_feature),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_class  (out_class),
        .out_score  (out_score)
`ifdef ARGMAX_MARGIN_EN
        ,
        .out_margin (out_margin)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Presents img[0..n-1] with in_valid held high, one beat per accepted cycle.
    task automatic send_beats(input int n);
        for (int i = 0; i < n; i++) begin
            int g;
            in_valid   = 1'b1;
            in_feature = img[i];
            g = 0;
            while (!in_ready && g < 20) begin
                tick();
                g++;
            end
            check("beat_in_ready", 32'(in_ready), 32'd1);
            if (i == 9) check("out_valid_before_last", 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_feature = '0; out_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_class", 32'(out_class), 32'd0);
        check("rst_out_score", 32'(out_score), 32'd0);

        // Basic image, max at class 2
        img = '{16'h0010, 16'h0020, 16'h7FFF, 16'h0005, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send_beats(10);
        check("A_out_valid", 32'(out_valid), 32'd1);
        check("A_in_ready", 32'(in_ready), 32'd0);
        check("A_class", 32'(out_class), 32'd2);
        check("A_score", 32'(out_score), 32'h7FFF);
`ifdef ARGMAX_MARGIN_EN
        check("A_margin", 32'(out_margin), 32'h7FDF);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("A_hs_out_valid", 32'(out_valid), 32'd0);
        check("A_hs_in_ready", 32'(in_ready), 32'd1);
        check("A_hold_class", 32'(out_class), 32'd2);
        check("A_hold_score", 32'(out_score), 32'h7FFF);

        // All negative, -1 at class 0
        for (int i = 0; i < 10; i++) img[i] = 16'(-(i + 1));
        send_beats(10);
        check("B_class", 32'(out_class), 32'd0);
        check("B_score", 32'(out_score), 32'hFFFF);
`ifdef ARGMAX_MARGIN_EN
        check("B_margin", 32'(out_margin), 32'd1);
`endif
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // Tie between classes 3 and 7
        img = '{16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0, 16'h0, 16'h0100, 16'h0, 16'h0};
        send_beats(10);
        check("C_class", 32'(out_class), 32'd3);
        check("C_score", 32'(out_score), 32'h0100);
`ifdef ARGMAX_MARGIN_EN
        check("C_margin", 32'(out_margin), 32'd0);
`endif

        // Stall 5 cycles with stray in_valid beats that must be ignored
        in_valid = 1'b1; in_feature = 16'h7000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_class", 32'(out_class), 32'd3);
            check("stall_score", 32'(out_score), 32'h0100);
        end
        in_valid = 1'b0;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("stall_release", 32'(in_ready), 32'd1);

        // Two back-to-back images with out_ready held: 22 cycles total
        for (int i = 0; i < 20; i++) img2[i] = (i < 10) ? 16'h0010 : 16'h0001;
        img2[5] = 16'h0050; img2[19] = 16'h0090;
        out_ready = 1'b1; idx = 0; nres = 0;
        for (int c = 0; c < 22; c++) begin
            in_valid   = (idx < 20);
            in_feature = (idx < 20) ? img2[idx] : 16'h0;
            acc = in_valid & in_ready;
            if (out_valid && nres < 2) begin
                res_class[nres] = out_class;
                res_score[nres] = out_score;
                nres++;
            end
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        check("b2b_results", 32'(nres), 32'd2);
        check("b2b_beats", 32'(idx), 32'd20);
        check("b2b_class0", 32'(res_class[0]), 32'd5);
        check("b2b_score0", 32'(res_score[0]), 32'h0050);
        check("b2b_class1", 32'(res_class[1]), 32'd9);
        check("b2b_score1", 32'(res_score[1]), 32'h0090);
        check("b2b_in_ready", 32'(in_ready), 32'd1);

        // Reset mid-image after 5 beats, then a fresh image
        img = '{16'h0, 16'h0, 16'h0500, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        send_beats(5);
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_score", 32'(out_score), 32'd0);
        img = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0030, 16'h0};
        send_beats(10);
        check("D_out_valid", 32'(out_valid), 32'd1);
        check("D_class", 32'(out_class), 32'd8);
        check("D_score", 32'(out_score), 32'h0030);
        reset = 1'b1; tick(); reset = 1'b0;
        check("res_rst_out_valid", 32'(out_valid), 32'd0);
        check("res_rst_in_ready", 32'(in_ready), 32'd1);

        // Margin vectors; class/score are checked in both builds
        img = '{16'h0, 16'h0200, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0180, 16'h0, 16'h0, 16'h0};
        send_beats(10);
        check("E_class", 32'(out_class), 32'd1);
        check("E_score", 32'(out_score), 32'h0200);
`ifdef ARGMAX_MARGIN_EN
        check("E_margin", 32'(out_margin), 32'h0080);
`endif
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        for (int i = 0; i < 10; i++) img[i] = 16'h8000;
        img[4] = 16'h7FFF;
        send_beats(10);
        check("F_class", 32'(out_class), 32'd4);
        check("F_score", 32'(out_score), 32'h7FFF);
`ifdef ARGMAX_MARGIN_EN
        check("F_margin", 32'(out_margin), 32'hFFFF);
`endif
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        check("F_hs_out_valid", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
